cam_cfg_seq: RTL and testbench

Parametrised camera register-configuration sequencer. It walks a synchronous configuration ROM of {register address, register data} entries, which may hold several selectable profiles. It issues each write to the SCCB master through a valid/ready/done handshake and executes in-table delay entries. Failed writes are retried, and a completion or error status is reported to the top-level camera controller.

---
 rtl/cam_cfg_seq.sv | 183 ++++++++++++++++++
 tb/tb_cam_cfg_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cfg_seq.sv
// Camera register-configuration sequencer: walks a profile-selected ROM table, issues
// SCCB writes with NACK retry, executes in-table delays and reports done/error status.
module cam_cfg_seq #(
    parameter int RA_W        = 8,
    parameter int RD_W        = 8,
    parameter int IDX_W       = 8,
    parameter int PROF_W      = 1,
    parameter int TICK_CYCLES = 24000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    input  logic [PROF_W-1:0]       i_profile,
    output logic [PROF_W+IDX_W-1:0] o_rom_addr,
    input  logic [RA_W+RD_W-1:0]    i_rom_dout,
    output logic                    o_wr_valid,
    output logic [RA_W-1:0]         o_wr_addr,
    output logic [RD_W-1:0]         o_wr_data,
    input  logic                    i_wr_ready,
    input  logic                    i_wr_done,
    input  logic                    i_wr_nack,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [IDX_W:0]          o_wr_count
);

    localparam int CNT_W = RD_W + $clog2(TICK_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
        S_DECODE,
        S_WRITE,
        S_WAITDONE,
        S_DELAY,
        S_FINISH,
        S_ABORT
    } state_t;

    state_t               state_q;
    logic [PROF_W-1:0]    prof_q;
    logic [IDX_W-1:0]     idx_q;
    logic [RA_W+RD_W-1:0] entry_q;
    logic [CNT_W-1:0]     delayCnt_q;
    logic [RTY_W-1:0]     retryCnt_q;

    logic [RA_W-1:0]  entAddr;
    logic [RD_W-1:0]  entData;
    logic             isDelay;
    logic             isEnd;
    logic             lastIdx;
    logic             canRetry;
    logic [IDX_W-1:0] idx_d;
    logic [CNT_W-1:0] delayLoad_d;

    assign entAddr  = entry_q[RA_W+RD_W-1:RD_W];
    assign entData  = entry_q[RD_W-1:0];
    assign isDelay  = &entAddr;
    assign isEnd    = isDelay & (&entData);
    assign lastIdx  = &idx_q;
    assign canRetry = retryCnt_q < RTY_W'(MAX_RETRY);
    assign idx_d    = idx_q + IDX_W'(1);

    // Counter is wide enough for the largest D*TICK_CYCLES, so the product is exact
    assign delayLoad_d = CNT_W'(entData) * CNT_W'(TICK_CYCLES);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            prof_q     <= '0;
            idx_q      <= '0;
            entry_q    <= '0;
            delayCnt_q <= '0;
            retryCnt_q <= '0;
            o_rom_addr <= '0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_wr_count <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        prof_q     <= i_profile;
                        idx_q      <= '0;
                        retryCnt_q <= '0;
                        o_rom_addr <= {i_profile, {IDX_W{1'b0}}};
                        o_err      <= 1'b0;
                        o_wr_count <= '0;
                        o_busy     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_ROMWAIT;
                end
                S_ROMWAIT: begin
                    entry_q <= i_rom_dout;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (isEnd) begin
                        o_done  <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (isDelay) begin
                        delayCnt_q <= delayLoad_d;
                        state_q    <= S_DELAY;
                    end else begin
                        o_wr_addr  <= entAddr;
                        o_wr_data  <= entData;
                        o_wr_valid <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i_wr_ready) begin
                        o_wr_valid <= 1'b0;
                        state_q    <= S_WAITDONE;
                    end
                end
                // A retry reissues the same payload, which is still held in o_wr_addr/o_wr_data
                S_WAITDONE: begin
                    if (i_wr_done) begin
                        if (!i_wr_nack) begin
                            o_wr_count <= o_wr_count + (IDX_W+1)'(1);
                            retryCnt_q <= '0;
                            if (lastIdx) begin
                                o_done  <= 1'b1;
                                state_q <= S_FINISH;
                            end else begin
                                idx_q      <= idx_d;
                                o_rom_addr <= {prof_q, idx_d};
                                state_q    <= S_FETCH;
                            end
                        end else if (canRetry) begin
                            retryCnt_q <= retryCnt_q + RTY_W'(1);
                            o_wr_valid <= 1'b1;
                            state_q    <= S_WRITE;
                        end else begin
                            o_err   <= 1'b1;
                            state_q <= S_ABORT;
                        end
                    end
                end
                // Leaving on a count of 1 gives exactly D*TICK_CYCLES cycles, and a zero load still spends one
                S_DELAY: begin
                    if (delayCnt_q <= CNT_W'(1)) begin
                        if (lastIdx) begin
                            o_done  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            idx_q      <= idx_d;
                            o_rom_addr <= {prof_q, idx_d};
                            state_q    <= S_FETCH;
                        end
                    end else begin
                        delayCnt_q <= delayCnt_q - CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    o_busy  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Bench for cam_cfg_seq: synchronous ROM and SCCB slave models, a table of directed runs,
// multi-cycle corner sequences and randomized tables checked against a table-walking reference.
module tb_cam_cfg_seq;

    localparam int RA_W      = 8;
    localparam int RD_W      = 8;
    localparam int IDX_W     = 3;
    localparam int PROF_W    = 1;
    localparam int TICK      = 4;
    localparam int MAXR      = 3;
    localparam int DEPTH     = 1 << IDX_W;
    localparam int BUDGET    = 3000;
    localparam int NVEC      = 10;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    start;
    logic [PROF_W-1:0]       profile;
    logic [PROF_W+IDX_W-1:0] romAddr;
    logic [RA_W+RD_W-1:0]    romDout = '0;
    logic                    wrValid;
    logic [RA_W-1:0]         wrAddr;
    logic [RD_W-1:0]         wrData;
    logic                    wrReady = 1'b0;
    logic                    wrDone = 1'b0;
    logic                    wrNack = 1'b0;
    logic                    seqBusy;
    logic                    seqDone;
    logic                    seqErr;
    logic [IDX_W:0]          wrCount;

    cam_cfg_seq #(
        .RA_W(RA_W), .RD_W(RD_W), .IDX_W(IDX_W), .PROF_W(PROF_W),
        .TICK_CYCLES(TICK), .MAX_RETRY(MAXR)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_profile(profile),
        .o_rom_addr(romAddr), .i_rom_dout(romDout),
        .o_wr_valid(wrValid), .o_wr_addr(wrAddr), .o_wr_data(wrData),
        .i_wr_ready(wrReady), .i_wr_done(wrDone), .i_wr_nack(wrNack),
        .o_busy(seqBusy), .o_done(seqDone), .o_err(seqErr), .o_wr_count(wrCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [2*DEPTH];
    always @(posedge clk) romDout <= rom[romAddr];

    // Configuration written by the main process, consumed by the agent on each new run
    int runId = 0;
    int doneLatCfg = 4;
    int readyModeCfg = 0;
    int holdLowCfg = 0;
    int runProfile = 0;
    bit nackPlan [64];

    // Observations owned by the agent
    logic [15:0] obsReq [$];
    int          validRise [$];
    int          doneCyc [$];
    int          acceptCyc [$];
    int          doneCount = 0;
    bit          stableBad = 0;
    bit          profBad = 0;

    // Reference results
    logic [15:0] expReq [$];
    int          expGap [$];
    int          expCount, expErr, expDone;

    int checks = 0;
    int errors = 0;
    int startCyc = 0;

    typedef struct {
        int romSel; int prof; int nackFirst; int lat; int rmode;
        int expReqs; int expCount; int expErr; int expDone; int expGap1;
    } vec_t;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // SCCB slave, ready generator and output monitor in one process so sampling order is fixed
    initial begin : agent
        int          seenRun;
        int          busyCnt;
        int          holdLeft;
        int          attemptIdx;
        logic        pv, pr;
        logic [15:0] pp;
        seenRun = 0; busyCnt = 0; holdLeft = 0; attemptIdx = 0;
        pv = 1'b0; pr = 1'b0; pp = '0;
        forever begin
            @(negedge clk);
            if (runId != seenRun) begin
                seenRun = runId;
                obsReq.delete(); validRise.delete(); doneCyc.delete(); acceptCyc.delete();
                busyCnt = 0; holdLeft = holdLowCfg; attemptIdx = 0;
                doneCount = 0; stableBad = 0; profBad = 0;
            end
            if (pv && !pr && (wrValid !== 1'b1 || {wrAddr, wrData} !== pp)) stableBad = 1;
            if (wrValid && !pv) validRise.push_back(cyc);
            if (seqBusy && romAddr[IDX_W] !== 1'(runProfile)) profBad = 1;
            if (seqDone) doneCount++;
            wrDone = 1'b0;
            wrNack = 1'b0;
            if (busyCnt > 0) begin
                busyCnt--;
                if (busyCnt == 0) begin
                    wrDone = 1'b1;
                    wrNack = nackPlan[attemptIdx % 64];
                    attemptIdx++;
                    doneCyc.push_back(cyc);
                end
            end
            if (holdLeft > 0) begin
                wrReady = 1'b0;
                holdLeft--;
            end else if (readyModeCfg == 1) wrReady = 1'($urandom % 2);
            else wrReady = 1'b1;
            if (wrValid && wrReady) begin
                obsReq.push_back({wrAddr, wrData});
                acceptCyc.push_back(cyc);
                busyCnt = doneLatCfg;
            end
            pv = wrValid;
            pr = wrReady;
            pp = {wrAddr, wrData};
        end
    end

    task automatic loadRom(input int sel);
        for (int a = 0; a < 2*DEPTH; a++) rom[a] = 16'hFFFF;
        case (sel)
            0: begin
                rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
                rom[8] = 16'h2A55; rom[9] = 16'h2B66; rom[10] = 16'h2C77; rom[11] = 16'hFFFF;
            end
            1: begin
                rom[0] = 16'h1280; rom[1] = 16'hFF03; rom[2] = 16'h1100; rom[3] = 16'hFFFF;
                rom[8] = 16'h3301; rom[9] = 16'hFF00; rom[10] = 16'h3402; rom[11] = 16'hFFFF;
            end
            default: begin
                for (int a = 0; a < DEPTH; a++) rom[a] = 16'h4000 + 16'(a * 257);
                rom[8] = 16'hFFFF;
            end
        endcase
    endtask

    // Walks the table by the entry rules: every entry costs fetch+romwait+decode, a delay
    // entry adds max(1, D*TICK), a write waits one cycle after the previous done.
    task automatic modelRun(input int prof);
        int          idx, attempt, retry, pend;
        bit          fin, written;
        logic [15:0] e;
        expReq.delete(); expGap.delete();
        expCount = 0; expErr = 0; expDone = 0;
        idx = 0; attempt = 0; retry = 0; pend = 1; fin = 0;
        while (!fin) begin
            e = rom[prof*DEPTH + idx];
            pend += 3;
            if (e == 16'hFFFF) begin
                expDone = 1;
                fin = 1;
            end else begin
                if (e[15:8] == 8'hFF) begin
                    pend += (e[7:0] == 8'h00) ? 1 : int'(e[7:0]) * TICK;
                end else begin
                    written = 0;
                    while (!written && expErr == 0) begin
                        expReq.push_back(e);
                        expGap.push_back(pend);
                        pend = 1;
                        if (!nackPlan[attempt % 64]) begin
                            written = 1; expCount++; retry = 0;
                        end else if (retry < MAXR) retry++;
                        else expErr = 1;
                        attempt++;
                    end
                end
                if (expErr != 0) fin = 1;
                else if (idx == DEPTH-1) begin
                    expDone = 1;
                    fin = 1;
                end else idx++;
            end
        end
    endtask

    task automatic pulseReset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic applyStimulus(input int prof, input int lat, input int rmode, input int hold,
                                 input int flipAt, input int againAt, output bit timedOut);
        int n;
        doneLatCfg = lat; readyModeCfg = rmode; holdLowCfg = hold; runProfile = prof;
        runId++;
        @(negedge clk);
        @(negedge clk);
        profile = 1'(prof);
        start = 1'b1;
        startCyc = cyc;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (seqBusy && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (n == flipAt) profile = ~profile;
            start = (n == againAt);
        end
        start = 1'b0;
        timedOut = (n >= BUDGET);
        if (timedOut) pulseReset();
    endtask

    task automatic checkRun(input string tag, input bit timedOut);
        int g;
        modelRun(runProfile);
        checkOutput({tag, " timeout"}, longint'(timedOut), 0);
        checkOutput({tag, " reqs"}, obsReq.size(), expReq.size());
        for (int i = 0; i < expReq.size() && i < obsReq.size(); i++) begin
            checkOutput($sformatf("%s req%0d", tag, i), obsReq[i], expReq[i]);
            if (i < validRise.size() && (i == 0 || i-1 < doneCyc.size())) begin
                g = validRise[i] - ((i == 0) ? startCyc : doneCyc[i-1]);
                checkOutput($sformatf("%s gap%0d", tag, i), g, expGap[i]);
            end
        end
        checkOutput({tag, " count"}, wrCount, expCount);
        checkOutput({tag, " err"}, seqErr, expErr);
        checkOutput({tag, " donePulses"}, doneCount, expDone);
        checkOutput({tag, " busyAfter"}, seqBusy, 0);
        checkOutput({tag, " validStable"}, stableBad, 0);
        checkOutput({tag, " romProfile"}, profBad, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"}, seqBusy, 0);
        checkOutput({tag, " done"}, seqDone, 0);
        checkOutput({tag, " err"}, seqErr, 0);
        checkOutput({tag, " valid"}, wrValid, 0);
        checkOutput({tag, " addr"}, wrAddr, 0);
        checkOutput({tag, " data"}, wrData, 0);
        checkOutput({tag, " romAddr"}, romAddr, 0);
        checkOutput({tag, " count"}, wrCount, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit to;
        int g, n;
        //        rom prof nack lat rdy  reqs cnt err done gap1
        vecs[0] = '{0, 0, 0, 10, 0,  2, 2, 0, 1, 4};
        vecs[1] = '{0, 1, 0,  3, 0,  3, 3, 0, 1, 4};
        vecs[2] = '{1, 0, 0,  2, 0,  2, 2, 0, 1, 19};
        vecs[3] = '{1, 1, 0,  2, 0,  2, 2, 0, 1, 8};
        vecs[4] = '{0, 0, 2,  4, 0,  4, 2, 0, 1, 1};
        vecs[5] = '{0, 0, 4,  4, 0,  4, 0, 1, 0, 1};
        vecs[6] = '{2, 0, 0,  1, 0,  8, 8, 0, 1, 4};
        vecs[7] = '{2, 1, 0,  1, 0,  0, 0, 0, 1, -1};
        vecs[8] = '{0, 1, 3,  2, 0,  6, 3, 0, 1, 1};
        vecs[9] = '{2, 0, 1,  3, 1,  9, 8, 0, 1, 1};

        rstn = 1'b1; start = 1'b0; profile = '0;
        for (int i = 0; i < 64; i++) nackPlan[i] = 0;
        loadRom(0);
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rstn = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            loadRom(vecs[v].romSel);
            for (int i = 0; i < 64; i++) nackPlan[i] = (i < vecs[v].nackFirst);
            applyStimulus(vecs[v].prof, vecs[v].lat, vecs[v].rmode, 0, -1, -1, to);
            checkRun($sformatf("vec%0d", v), to);
            checkOutput($sformatf("vec%0d tblReqs", v), obsReq.size(), vecs[v].expReqs);
            checkOutput($sformatf("vec%0d tblCount", v), wrCount, vecs[v].expCount);
            checkOutput($sformatf("vec%0d tblErr", v), seqErr, vecs[v].expErr);
            checkOutput($sformatf("vec%0d tblDone", v), doneCount, vecs[v].expDone);
            if (vecs[v].expGap1 >= 0) begin
                g = (validRise.size() > 1 && doneCyc.size() > 0) ? validRise[1] - doneCyc[0] : -1;
                checkOutput($sformatf("vec%0d tblGap1", v), g, vecs[v].expGap1);
            end
        end

        // Ready held low for 50 cycles while a request is pending
        loadRom(0);
        for (int i = 0; i < 64; i++) nackPlan[i] = 0;
        applyStimulus(0, 5, 0, 50, -1, -1, to);
        checkRun("holdLow", to);
        g = (acceptCyc.size() > 0 && validRise.size() > 0) ? acceptCyc[0] - validRise[0] : -1;
        checkOutput("holdLow waitedForReady", longint'(g >= 40), 1);

        // Profile input toggled mid-run must not redirect the ROM walk
        applyStimulus(1, 3, 0, 0, 6, -1, to);
        checkRun("profFlip", to);

        // Start pulsed while busy must not restart the sequence
        applyStimulus(0, 8, 0, 0, -1, 10, to);
        checkRun("startBusy", to);

        // Reset during WAITDONE, then a clean rerun from index 0
        doneLatCfg = 10; readyModeCfg = 0; holdLowCfg = 0; runProfile = 0;
        runId++;
        @(negedge clk);
        profile = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!wrValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midReset reachedWrite", longint'(n < 20), 1);
        repeat (3) @(negedge clk);
        checkOutput("midReset inWaitDone", longint'(seqBusy && !wrValid), 1);
        rstn = 1'b0;
        #1;
        checkResetValues("midReset");
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(0, 4, 0, 0, -1, -1, to);
        checkRun("afterReset", to);

        // Randomized tables, profiles, NACK patterns, ready behaviour and done latency
        for (int it = 0; it < 24; it++) begin
            int r;
            for (int a = 0; a < 2*DEPTH; a++) begin
                r = int'($urandom % 10);
                if (r == 0) rom[a] = 16'hFFFF;
                else if (r < 3) rom[a] = {8'hFF, 8'($urandom % 4)};
                else rom[a] = {8'($urandom % 255), 8'($urandom)};
            end
            for (int i = 0; i < 64; i++) nackPlan[i] = ($urandom % 5 == 0);
            applyStimulus(int'($urandom % 2), 1 + int'($urandom % 6), int'($urandom % 2), 0, -1, -1, to);
            checkRun($sformatf("rand%0d", it), to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
